// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with parity/stop checking and a handshaked holding register
module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] RxD_data,
  output logic                 RxD_valid,
  input  logic                 RxD_ready,
  output logic                 Parity_err,
  output logic                 Frame_err,
  output logic                 Overrun,
  output logic                 RxD_idle
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 sync1;
  logic                 sync2;
  logic                 sync_prev;
  logic [CW-1:0]        clk_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad;
  logic                 stop_bad;
  logic                 start_det;
  logic                 tick;
  logic                 data_last;
  logic                 stop_last;

  // Falling edge only: a line stuck low cannot retrigger a frame.
  assign start_det = sync_prev & ~sync2;
  assign tick      = (clk_cnt == '0);

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_det) state_nxt = S_START;
      S_START:  if (tick) state_nxt = sync2 ? S_IDLE : S_DATA;
      S_DATA:   if (data_last) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_nxt = S_STOP;
      S_STOP:   if (stop_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    RxD_idle  = (state == S_IDLE);
    data_last = (state == S_DATA) && tick && (bit_cnt == LAST_DATA);
    stop_last = (state == S_STOP) && tick && (bit_cnt == LAST_STOP);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      sync_prev  <= 1'b1;
      clk_cnt    <= HALF_M1;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      RxD_data   <= '0;
      RxD_valid  <= 1'b0;
      Parity_err <= 1'b0;
      Frame_err  <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      sync1     <= RxD;
      sync2     <= sync1;
      sync_prev <= sync2;

      // Half-bit preload in IDLE puts every sample in the middle of its bit.
      if (state == S_IDLE) clk_cnt <= HALF_M1;
      else if (tick)       clk_cnt <= FULL_M1;
      else                 clk_cnt <= clk_cnt - 1'b1;

      if (state != state_nxt)
        bit_cnt <= '0;
      else if (tick && (state == S_DATA || state == S_STOP))
        bit_cnt <= bit_cnt + 1'b1;

      if (state == S_IDLE) begin
        shift    <= '0;
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
      end else if (tick) begin
        if (state == S_DATA)   shift <= {sync2, shift[DATA_BITS-1:1]};
        // Odd mode flips the sense of the even-parity check.
        if (state == S_PARITY) par_bad <= (^shift) ^ sync2 ^ (PARITY == 2);
        if (state == S_STOP && !sync2) stop_bad <= 1'b1;
      end

      Overrun <= 1'b0;
      if (stop_last) begin
        if (!RxD_valid || RxD_ready) begin
          RxD_data   <= shift;
          Parity_err <= par_bad;
          Frame_err  <= stop_bad | ~sync2;
          RxD_valid  <= 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end else if (RxD_ready) begin
        RxD_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised, oversampling UART receiver replacing the fixed 8-bit, externally-framed receiver. It recovers frames from the raw serial line without a separate framing strobe:
- start-bit detection with false-start rejection, mid-bit sampling, configurable word width, parity mode and stop-bit count;
- a holding register with valid/ready handshake plus parity, framing and overrun reporting.

It sits between the RxD pin and the byte-level consumer (FIFO or controller) in the UART datapath.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9, LSB received first
- CLKS_PER_BIT, 16, Clk cycles per bit period, even, >= 4
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
- Clk  input  1  system clock, all logic on rising edge
- Rst  input  1  synchronous, active-high reset
- RxD  input  1  asynchronous serial line, idle high
- RxD_data  output  DATA_BITS  received word, valid while RxD_valid=1
- RxD_valid  output  1  holding register full
- RxD_ready  input  1  consumer accepts word when RxD_valid && RxD_ready at a rising edge
- Parity_err  output  1  parity mismatch for the held word, qualified by RxD_valid; 0 when PARITY=0
- Frame_err  output  1  any stop bit sampled 0 for the held word, qualified by RxD_valid
- Overrun  output  1  one-cycle pulse: completed frame dropped because holding register full
- RxD_idle  output  1  1 while FSM in IDLE

## Operation
- RxD passes through a 2-flop synchronizer; sync flops reset to 1. Start detect is synchronized sample 0 with previous sample 1, i.e. a falling edge; a line held low never retriggers.
- FSM states: IDLE, START, DATA, PARITY (skipped when PARITY=0), STOP.
- IDLE -> START on start detect; bit counter cleared, shift register cleared.
- START: after CLKS_PER_BIT/2 cycles, sample the line. If 1, this is a false start: go to IDLE. If 0, go to DATA.
- DATA: sample every CLKS_PER_BIT cycles and shift in LSB first. After DATA_BITS samples, go to PARITY or STOP.
- PARITY: one sample. Even mode: error if XOR(data, bit) = 1. Odd mode: error if it = 0.
- STOP: STOP_BITS samples; any 0 sets frame error. After the final stop sample, load the holding register and go to IDLE in the same cycle, so a back-to-back start is caught.
- Load: RxD_data, Parity_err and Frame_err update together, and RxD_valid is set. If RxD_valid=1 and not being accepted that cycle, the new word is discarded, the old word is kept, and Overrun pulses.
- Accept and load in the same cycle: load wins, RxD_valid stays 1, new word presented.
- Reset (any state, mid-frame included): FSM to IDLE, frame aborted, holding register emptied.

## Timing
- Reset values: RxD_data=0, RxD_valid=0, Parity_err=0, Frame_err=0, Overrun=0, RxD_idle=1.
- Let E = the edge on which start detect is registered. The start bit is sampled at E + CLKS_PER_BIT/2. Frame bit k is sampled at E + CLKS_PER_BIT/2 + k*CLKS_PER_BIT, for k = 1..N-1, where N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.
- RxD_valid rises one cycle after the final stop sample. Overrun pulses in that same cycle.
- Pin-to-E latency is 3 cycles (2 synchronizer flops + edge register).
- RxD_valid falls the cycle after acceptance. The minimum valid width is 1 cycle.
- RxD_idle is 0 from E+1 until the cycle after the final stop sample or false-start rejection.

## Test plan
Defaults for scenarios 1-5: CLKS_PER_BIT=16, DATA_BITS=8, PARITY=1, STOP_BITS=1, RxD_ready=1.
1. Frame 0xA5, parity bit 0, stop 1 -> RxD_data=0xA5, RxD_valid high exactly at E+169 for 1 cycle, Parity_err=0, Frame_err=0.
2. Frame 0x01, parity bit 0 (wrong) -> RxD_data=0x01, Parity_err=1, Frame_err=0.
3. Frame 0x7E, correct parity, stop bit 0, line then held low 40 cycles before rising -> Frame_err=1 with data 0x7E; no further RxD_valid until the line returns high and a new falling edge occurs.
4. Line low for 4 cycles, then high -> no RxD_valid; RxD_idle back to 1 at E+9; a following 0x3C frame is received correctly.
5. RxD_ready=0, back-to-back frames 0x11 then 0x22 -> RxD_data stays 0x11, Overrun pulses 1 cycle at 0x22 completion. Raise RxD_ready -> RxD_valid drops the next cycle.
6. DATA_BITS=7, PARITY=2, STOP_BITS=2, frame 0x55, assert Rst after 3 data bits -> RxD_idle=1, RxD_valid=0 the next cycle. A subsequent 0x2A frame completes 1 cycle after its second stop sample with no errors.
